// File: rtl/mini_alu_sequencer.sv
// mini_alu_sequencer: multi-cycle decode/execute stage fed by a PC-addressed ROM.
// Each instruction takes FETCH -> DECODE -> EXEC; EXEC issues one PC action
// (increment or jump load) and, for LDI/ADD/SUB, writes a 4-entry register file.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   synchronous, active-high
//   iInstruction  in   ROM word at the current PC
//   oPCEnable     out  one-cycle pulse, PC += 2
//   oPCLoad       out  one-cycle pulse, PC <= oPCTarget
//   oPCTarget     out  jump target byte address, {imm8, 1'b0}
//   oResult       out  last value written to the register file
//   oResultValid  out  one-cycle pulse when oResult updates
//   oZero         out  zero flag
//   oCarry        out  carry / borrow flag
//   oHalted       out  high while halted
module mini_alu_sequencer #(
    parameter int unsigned DATA = 8,
    parameter int unsigned ADDR = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     iInstruction,
    output logic            oPCEnable,
    output logic            oPCLoad,
    output logic [ADDR-1:0] oPCTarget,
    output logic [DATA-1:0] oResult,
    output logic            oResultValid,
    output logic            oZero,
    output logic            oCarry,
    output logic            oHalted
);

    localparam logic [3:0] OpLdi  = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpJmp  = 4'd4;
    localparam logic [3:0] OpJz   = 4'd5;
    localparam logic [3:0] OpHalt = 4'd6;

    typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [15:0]     r_ir;
    logic [DATA-1:0] r_a;
    logic [DATA-1:0] r_b;
    logic [DATA-1:0] r_rf [4];

    logic [3:0]      w_op;
    logic [1:0]      w_rd;
    logic [DATA-1:0] w_imm;
    logic [DATA-1:0] w_opa;
    logic [DATA-1:0] w_opb;
    logic [DATA:0]   w_sum;
    logic [DATA:0]   w_diff;
    logic [DATA-1:0] w_exec_val;
    logic            w_writes_rf;

    assign w_op        = r_ir[15:12];
    assign w_rd        = r_ir[11:10];
    assign w_imm       = DATA'(r_ir[7:0]);
    assign w_opa       = r_rf[r_ir[9:8]];
    assign w_opb       = r_rf[r_ir[1:0]];
    assign w_sum       = {1'b0, w_opa} + {1'b0, w_opb};
    // Top bit of the extended difference is the unsigned borrow (A < B).
    assign w_diff      = {1'b0, w_opa} - {1'b0, w_opb};
    assign w_writes_rf = (w_op == OpLdi) || (w_op == OpAdd) || (w_op == OpSub);
    assign oHalted     = (r_state == StHalt);

    // Register-file write data, computed from the operands latched in DECODE.
    always_comb begin
        w_exec_val = w_imm;
        if (w_op == OpAdd) begin
            w_exec_val = r_a + r_b;
        end else if (w_op == OpSub) begin
            w_exec_val = r_a - r_b;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: w_state_next = StExec;
            StExec:   w_state_next = (w_op == OpHalt) ? StHalt : StFetch;
            StHalt:   w_state_next = StHalt;
            default:  w_state_next = StFetch;
        endcase
    end

    // Outputs and flags are registered on the edge ending DECODE so they are
    // visible throughout EXEC; the PC then moves on the edge ending EXEC.
    // The flags cannot change between DECODE and EXEC, so deciding JZ here
    // is equivalent to deciding it in EXEC.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            oPCEnable    <= 1'b0;
            oPCLoad      <= 1'b0;
            oPCTarget    <= '0;
            oResult      <= '0;
            oResultValid <= 1'b0;
            oZero        <= 1'b0;
            oCarry       <= 1'b0;
        end else begin
            oPCEnable    <= 1'b0;
            oPCLoad      <= 1'b0;
            oResultValid <= 1'b0;
            unique case (r_state)
                StFetch: begin
                    r_ir <= iInstruction;
                end
                StDecode: begin
                    r_a <= w_opa;
                    r_b <= w_opb;
                    unique case (w_op)
                        OpLdi: begin
                            oResult      <= w_imm;
                            oResultValid <= 1'b1;
                            oZero        <= (w_imm == '0);
                            oCarry       <= 1'b0;
                            oPCEnable    <= 1'b1;
                        end
                        OpAdd: begin
                            oResult      <= w_sum[DATA-1:0];
                            oResultValid <= 1'b1;
                            oZero        <= (w_sum[DATA-1:0] == '0);
                            oCarry       <= w_sum[DATA];
                            oPCEnable    <= 1'b1;
                        end
                        OpSub: begin
                            oResult      <= w_diff[DATA-1:0];
                            oResultValid <= 1'b1;
                            oZero        <= (w_diff[DATA-1:0] == '0);
                            oCarry       <= w_diff[DATA];
                            oPCEnable    <= 1'b1;
                        end
                        OpJmp: begin
                            oPCLoad   <= 1'b1;
                            oPCTarget <= ADDR'({r_ir[7:0], 1'b0});
                        end
                        OpJz: begin
                            if (oZero) begin
                                oPCLoad   <= 1'b1;
                                oPCTarget <= ADDR'({r_ir[7:0], 1'b0});
                            end else begin
                                oPCEnable <= 1'b1;
                            end
                        end
                        OpHalt: begin
                        end
                        default: begin
                            oPCEnable <= 1'b1;
                        end
                    endcase
                end
                StExec: begin
                    if (w_writes_rf) begin
                        r_rf[w_rd] <= w_exec_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
